// File: rtl/popcount_frame_accum_pkg.sv
// Shared definitions for the frame popcount accumulator: FSM encoding and width helpers.
package popcount_frame_accum_pkg;

  localparam int unsigned DATA_W_DEF    = 8;
  localparam int unsigned MAX_WORDS_DEF = 16;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_OUT   = 1'b1
  } state_t;

  // Frame total must hold DATA_W*MAX_WORDS without wrapping.
  function automatic int unsigned sum_width(input int unsigned data_w,
                                            input int unsigned max_words);
    return $clog2(data_w * max_words + 1);
  endfunction

  function automatic int unsigned wcnt_width(input int unsigned max_words);
    return $clog2(max_words + 1);
  endfunction

endpackage

// File: rtl/popcount_frame_accum_bit_vector_sum.sv
// Combinational population count of one DATA_W-bit word.
module popcount_frame_accum_bit_vector_sum #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned POS_W  = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0] data,
  output logic [POS_W:0]    count_c
);

  always_comb begin
    count_c = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      count_c = count_c + {{POS_W{1'b0}}, data[i]};
    end
  end

endmodule

// File: rtl/popcount_frame_accum.sv
// Accumulates per-word popcounts over a frame and presents the total on a valid/ready output.
module popcount_frame_accum
  import popcount_frame_accum_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_WORDS = MAX_WORDS_DEF,
  parameter int unsigned POS_W     = $clog2(DATA_W),
  parameter int unsigned SUM_W     = sum_width(DATA_W, MAX_WORDS),
  parameter int unsigned WCNT_W    = wcnt_width(MAX_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [SUM_W-1:0]  m_sum,
  output logic [WCNT_W-1:0] m_words,
  output logic              m_overflow,
  output logic              m_valid,
  input  logic              m_ready
);

  state_t              state, state_nxt;
  logic [SUM_W-1:0]    acc, acc_nxt;
  logic [WCNT_W-1:0]   wcnt, wcnt_nxt;
  logic                ovf, ovf_nxt;
  logic [SUM_W-1:0]    m_sum_nxt;
  logic [WCNT_W-1:0]   m_words_nxt;
  logic                m_overflow_nxt;
  logic [POS_W:0]      word_cnt;

  popcount_frame_accum_bit_vector_sum #(
    .DATA_W (DATA_W),
    .POS_W  (POS_W)
  ) u_bit_vector_sum (
    .data    (s_data),
    .count_c (word_cnt)
  );

  // Next-state, accumulation and result capture.
  always_comb begin
    state_nxt      = state;
    acc_nxt        = acc;
    wcnt_nxt       = wcnt;
    ovf_nxt        = ovf;
    m_sum_nxt      = m_sum;
    m_words_nxt    = m_words;
    m_overflow_nxt = m_overflow;
    case (state)
      ST_ACCUM: begin
        if (s_valid && s_ready) begin
          if (wcnt < WCNT_W'(MAX_WORDS)) begin
            acc_nxt  = acc + SUM_W'(word_cnt);
            wcnt_nxt = wcnt + WCNT_W'(1);
          end else begin
            ovf_nxt = 1'b1;
          end
          // Result includes the last word itself when it still fits.
          if (s_last) begin
            m_sum_nxt      = acc_nxt;
            m_words_nxt    = wcnt_nxt;
            m_overflow_nxt = ovf_nxt;
            state_nxt      = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (m_valid && m_ready) begin
          acc_nxt   = '0;
          wcnt_nxt  = '0;
          ovf_nxt   = 1'b0;
          state_nxt = ST_ACCUM;
        end
      end
      default: state_nxt = ST_ACCUM;
    endcase
  end

  // Handshake flags are registered copies of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ACCUM;
      acc        <= '0;
      wcnt       <= '0;
      ovf        <= 1'b0;
      m_sum      <= '0;
      m_words    <= '0;
      m_overflow <= 1'b0;
      s_ready    <= 1'b1;
      m_valid    <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      wcnt       <= wcnt_nxt;
      ovf        <= ovf_nxt;
      m_sum      <= m_sum_nxt;
      m_words    <= m_words_nxt;
      m_overflow <= m_overflow_nxt;
      s_ready    <= (state_nxt == ST_ACCUM);
      m_valid    <= (state_nxt == ST_OUT);
    end
  end

endmodule

// File: doc/popcount_frame_accum.md
Name: popcount_frame_accum

Overview:
- Stream-side controller that sequences a combinational bit-vector population counter across multi-word frames.
- Accepts DATA_W-bit words over a valid/ready handshake and adds the set-bit count of each word into an accumulator.
- On the frame's last word, it presents the frame total, the word count and an overflow flag on an output valid/ready handshake.
- Sits between a packet/bitmap source and any consumer of per-frame ones-counts, for example density monitors or parity/weight checks.

Parameters:
- DATA_W, 8, width of each input word.
- MAX_WORDS, 16, maximum words counted per frame.
- POS_W, $clog2(DATA_W), width of the per-word popcount minus 1; the per-word count is POS_W+1 bits.
- SUM_W, $clog2(DATA_W*MAX_WORDS+1), width of the frame total.
- WCNT_W, $clog2(MAX_WORDS+1), width of the word counter.

Ports:
- clk, input, 1, clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- s_data, input, DATA_W, input word.
- s_valid, input, 1, input word valid.
- s_last, input, 1, marks the final word of a frame; qualified by s_valid.
- s_ready, output, 1, block can accept a word.
- m_sum, output, SUM_W, total set bits in the frame.
- m_words, output, WCNT_W, number of words counted (at most MAX_WORDS).
- m_overflow, output, 1, frame exceeded MAX_WORDS words.
- m_valid, output, 1, result valid.
- m_ready, input, 1, consumer accepts the result.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values:
  - state = ACCUM.
  - Accumulator, word counter, m_sum, m_words and m_overflow = 0.
  - m_valid = 0.
  - s_ready = 1.
- Reset asserted mid-frame or while a result is pending discards everything; there is no partial result.
- Two-state FSM, ACCUM and OUT.
- ACCUM state:
  - s_ready = 1 and m_valid = 0.
  - A word is accepted when s_valid & s_ready.
  - If word counter < MAX_WORDS: acc <= acc + popcount(s_data) and wcnt <= wcnt + 1.
  - Otherwise the word is accepted but not added, and the overflow flag is set sticky.
  - If the accepted word has s_last = 1, the counted result (including this word when wcnt < MAX_WORDS) is registered into m_sum, m_words and m_overflow, and the FSM moves to OUT.
  - Latency: m_valid rises on the cycle after the last word's handshake.
- OUT state:
  - s_ready = 0, m_valid = 1.
  - m_sum, m_words and m_overflow are held stable until m_ready.
  - On m_valid & m_ready: acc, wcnt and overflow are cleared, and the FSM returns to ACCUM, so s_ready = 1 on the next cycle.
  - There is no bypass: a new frame's first word cannot be accepted in the same cycle as the result handshake. Throughput is one frame per (words + 1) cycles minimum.
- s_last when s_valid = 0 is ignored. Words arriving while s_valid = 0 are ignored.
- A single-word frame (first word has s_last) is legal: m_words = 1.
- Arithmetic:
  - popcount is zero-extended to SUM_W before the add.
  - The accumulator cannot wrap, because SUM_W covers DATA_W*MAX_WORDS and adds stop at MAX_WORDS words.
- s_ready is a registered/state-derived output and has no combinational path from m_ready.

Decomposition:
- Shared package holds the FSM state encoding (ST_ACCUM, ST_OUT) and the width helper constants (SUM_W and WCNT_W derivation).
- One natural sub-module: bit_vector_sum (DATA_W in, POS_W+1-bit sum out), a combinational per-word popcount instantiated once on s_data.
- All sequencing, counting and the handshake live in popcount_frame_accum.

Test Plan:
- Reset: hold rst_n = 0 with random stimulus -> s_ready = 1, m_valid = 0, m_sum = 0 throughout; release -> first word accepted next edge.
- Three-word frame, DATA_W = 8: words 0xFF, 0x0F, 0x81, with s_last on 0x81 and m_ready = 1 -> one cycle after the last handshake m_valid = 1 with m_sum = 14, m_words = 3, m_overflow = 0; s_ready = 1 one cycle later.
- Backpressure: single-word frame 0xAA, hold m_ready = 0 for 5 cycles -> m_valid stays 1 and m_sum = 4 stays stable, s_ready = 0; s_valid pulses meanwhile are not accepted. Then m_ready = 1 -> clear, next frame starts fresh at 0.
- Overflow: MAX_WORDS = 16, send 18 words of 0xFF, last on the 18th -> m_sum = 128, m_words = 16, m_overflow = 1. The next frame of one word 0x01 -> m_sum = 1, m_overflow = 0.
- Gaps and stray last: s_valid toggling with s_last = 1 while s_valid = 0, frame 0x03, 0x07 -> the stray last is ignored; m_sum = 5, m_words = 2.
- Reset mid-operation: assert rst_n low after 2 words of a frame, and separately while in OUT -> outputs return to reset values asynchronously; the following frame 0x01 yields m_sum = 1, m_words = 1.
